instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter FQ_DEPTH, default 2: fetch-queue entries; only 2 is supported.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  word-aligned fetch address, bits[1:0]=0.
REQ-007 imem_ack  input  1  read done; imem_rdata valid this cycle.
REQ-008 imem_rdata  input  32  fetched instruction.
REQ-009 cu_wpcir  input  1  ID stall: 1=hold ID register and queue head.
REQ-010 cu_branch  input  1  taken branch/jump/jr/jal resolved in ID.
REQ-011 branch_target  input  32  redirect PC, valid when cu_branch=1.
REQ-012 if_instr  output  32  queue-head instruction (next into ID); 0 when queue empty.
REQ-013 if_valid  output  1  queue non-empty.
REQ-014 id_instr  output  32  IF/ID instruction register.
REQ-015 id_pc4  output  32  IF/ID PC+4 of id_instr.
REQ-016 id_valid  output  1  id_instr is real (0 = bubble).

Function
REQ-017 Queue entry = {pc4[31:0], instr[31:0]}; count 0..2; push on accepted ack, pop on ID advance.
REQ-018 FSM states IDLE, WAIT, DISCARD; one outstanding request maximum.
REQ-019 IDLE: if count<2 (after this cycle's pop) and no flush, register imem_req=1, imem_addr=pc, go WAIT; else imem_req=0.
REQ-020 WAIT: imem_req and imem_addr held stable until imem_ack=1; on ack push {pc+4, imem_rdata}, pc<=pc+4, go IDLE.
REQ-021 Flush = cu_branch=1; flush takes priority over cu_wpcir.
REQ-022 On flush: queue cleared, pc<=branch_target, id_instr<=0, id_valid<=0, id_pc4<=0 (no delay slot).
REQ-023 Flush in WAIT without ack: go DISCARD; imem_req held until ack; data dropped; then IDLE fetching branch_target.
REQ-024 Flush in same cycle as imem_ack: data dropped, FSM to IDLE, pc<=branch_target.
REQ-025 ID advance (cu_wpcir=0, no flush): queue non-empty -> id_* <= head, id_valid=1, pop; empty -> id_instr<=0, id_valid<=0.
REQ-026 cu_wpcir=1, no flush: id_* and queue head unchanged; fetching continues until count=2.
REQ-027 Push and pop in same cycle: count unchanged, order preserved.
REQ-028 PC arithmetic modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-029 Ack received in IDLE is ignored.

Reset
REQ-030 rst=1: pc=RESET_PC, FSM=IDLE, count=0, imem_req=0, imem_addr=0, id_instr=0, id_pc4=0, id_valid=0, if_instr=0, if_valid=0.
REQ-031 rst mid-request: outstanding request abandoned; ack after reset release while in IDLE ignored per REQ-029.

Structure
REQ-032 NOP encoding (32'h0), RESET_PC default and FSM state codes live in macro.vh.
REQ-033 The 2-entry queue is sub-module fetch_queue (push, pop, clear, head, count).

Verification
REQ-034 Zero-wait memory (ack one cycle after req), no stalls -> id_instr sequence from 0x0,0x4,0x8 with id_pc4 4,8,12, after first bubble id_valid=1 every cycle.
REQ-035 cu_wpcir=1 for 3 cycles with fast memory -> id_instr constant, count reaches 2, imem_req drops to 0, resumes on release with no loss/duplication.
REQ-036 cu_branch=1, branch_target=0x100 while request to 0x10 pending (ack 3 cycles later) -> 0x10 data dropped, next imem_addr=0x100, id_valid=0 one cycle after branch.
REQ-037 cu_branch and imem_ack same cycle -> acked data never appears on if_instr/id_instr; next fetch at branch_target.
REQ-038 Assert rst during WAIT, ack arrives 2 cycles after release -> all outputs at reset values, first fetch at RESET_PC, stray ack ignored.
REQ-039 Branch to 0xFFFF_FFFC -> next fetch address 0x0000_0000, id_pc4=0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Fetch FSM encoding, fetch-queue entry layout, NOP and reset PC.
package instr_fetch_unit_pkg;

    localparam logic [31:0] NOP          = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/instr_fetch_unit_queue.sv
// Two-entry fetch queue between instruction memory and the IF/ID register.
// Entry 0 is always the head; clear wins over push and pop.
module fetch_queue
    import instr_fetch_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  fq_entry_t  push_data,
    input  logic       pop,
    input  logic       clear,
    output fq_entry_t  head,
    output logic [1:0] count
);

    fq_entry_t e0, e1;

    assign head = e0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0    <= '0;
            e1    <= '0;
            count <= 2'd0;
        end else if (clear) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) e0 <= push_data;
                    else               e1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    e0    <= e1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Same-cycle push/pop: slide, then append behind the survivor
                    if (count == 2'd1) begin
                        e0 <= push_data;
                    end else begin
                        e0 <= e1;
                        e1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: single-outstanding memory requester feeding a 2-deep
// queue and the IF/ID register, with branch flush and ID stall handling.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          FQ_DEPTH = 2
)
(
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        cu_wpcir,
    input  logic        cu_branch,
    input  logic [31:0] branch_target,
    output logic [31:0] if_instr,
    output logic        if_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic        id_valid
);

    localparam logic [1:0] FQ_FULL = 2'(FQ_DEPTH);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n, addr_n;
    logic         req_n;
    logic         flush, advance, pop, push;
    logic [1:0]   fq_count, count_left, count_next;
    fq_entry_t    fq_head, fq_in;

    assign flush      = cu_branch;
    assign advance    = !cu_branch && !cu_wpcir;
    assign pop        = advance && (fq_count != 2'd0);
    assign push       = (state == S_WAIT) && imem_ack && !flush;
    assign count_left = fq_count - {1'b0, pop};
    assign count_next = count_left + {1'b0, push};
    assign fq_in      = '{pc4: imem_addr + 32'd4, instr: imem_rdata};

    assign if_valid = (fq_count != 2'd0);
    assign if_instr = if_valid ? fq_head.instr : NOP;

    fetch_queue u_fq (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (fq_in),
        .pop       (pop),
        .clear     (flush),
        .head      (fq_head),
        .count     (fq_count)
    );

    always_comb begin
        state_n = state;
        pc_n    = pc;
        req_n   = imem_req;
        addr_n  = imem_addr;
        unique case (state)
            S_IDLE: begin
                req_n = 1'b0;
                if (flush) begin
                    pc_n = branch_target;
                end else if (count_left < FQ_FULL) begin
                    req_n   = 1'b1;
                    addr_n  = pc;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ack && flush) begin
                    pc_n    = branch_target;
                    req_n   = 1'b0;
                    state_n = S_IDLE;
                end else if (imem_ack) begin
                    pc_n = pc + 32'd4;
                    // Chain the next request while room remains
                    if (count_next < FQ_FULL) begin
                        addr_n = pc + 32'd4;
                    end else begin
                        req_n   = 1'b0;
                        state_n = S_IDLE;
                    end
                end else if (flush) begin
                    pc_n    = branch_target;
                    state_n = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (flush) pc_n = branch_target;
                if (imem_ack) begin
                    req_n   = 1'b0;
                    state_n = S_IDLE;
                end
            end
            default: begin
                req_n   = 1'b0;
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= 32'h0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            imem_req  <= req_n;
            imem_addr <= addr_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_instr <= NOP;
            id_pc4   <= 32'h0;
            id_valid <= 1'b0;
        end else if (flush) begin
            id_instr <= NOP;
            id_pc4   <= 32'h0;
            id_valid <= 1'b0;
        end else if (advance) begin
            if (fq_count != 2'd0) begin
                id_instr <= fq_head.instr;
                id_pc4   <= fq_head.pc4;
                id_valid <= 1'b1;
            end else begin
                id_instr <= NOP;
                id_pc4   <= 32'h0;
                id_valid <= 1'b0;
            end
        end
    end

endmodule
